// File: rtl/collision_checker_if.sv
// ============================================================================
// Module      : collision_checker_if
// Description : Signal bundle between the obstacle/timing/mouse sources and
//               the collision checker, with its game-control/HUD outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface collision_checker_if;
    logic [11:0] hcount_in;
    logic [11:0] vcount_in;
    logic [11:0] obstacle_x;
    logic [11:0] obstacle_y;
    logic        working;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        game_on;
    logic        hit;
    logic [2:0]  lives;
    logic        invulnerable;
    logic        game_over;

    modport master (
        output hcount_in, vcount_in, obstacle_x, obstacle_y, working,
               mouse_xpos, mouse_ypos, game_on,
        input  hit, lives, invulnerable, game_over
    );

    modport slave (
        input  hcount_in, vcount_in, obstacle_x, obstacle_y, working,
               mouse_xpos, mouse_ypos, game_on,
        output hit, lives, invulnerable, game_over
    );
endinterface

`default_nettype wire

// File: rtl/collision_checker.sv
// ============================================================================
// Module      : collision_checker
// Description : Per-frame obstacle/pointer collision detection with lives,
//               invulnerability window and game-over tracking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module collision_checker #(
    parameter int POINTER_SIZE  = 12,
    parameter int LIVES         = 3,
    parameter int INVULN_FRAMES = 120
) (
    input  wire logic         pclk,
    input  wire logic         rst,
    collision_checker_if.slave bus
);

    localparam logic [12:0] c_PTR_EXT = 13'(POINTER_SIZE - 1);
    localparam logic [2:0]  c_LIVES   = 3'(LIVES);
    localparam logic [7:0]  c_INV     = 8'(INVULN_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_INVULN = 2'd2,
        S_OVER   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_hit;
    logic        w_hit_nxt;
    logic [2:0]  r_lives;
    logic [2:0]  w_lives_nxt;
    logic        r_invuln;
    logic        w_invuln_nxt;
    logic        r_over;
    logic        w_over_nxt;
    logic [7:0]  r_inv_cnt;
    logic [7:0]  w_inv_cnt_nxt;
    logic        r_coll_flag;
    logic        w_coll_flag_nxt;
    logic [11:0] r_mx;
    logic [11:0] r_my;

    logic        w_frame_start;
    logic [12:0] w_x_hi;
    logic [12:0] w_y_hi;
    logic        w_pixel_valid;
    logic        w_coll_now;
    logic        w_eval;

    assign w_frame_start = (bus.hcount_in == 12'd0) && (bus.vcount_in == 12'd0);

    // Upper box edges carry an extra bit so a pointer near 4095 cannot wrap to 0.
    assign w_x_hi = {1'b0, r_mx} + c_PTR_EXT;
    assign w_y_hi = {1'b0, r_my} + c_PTR_EXT;

    assign w_pixel_valid = (bus.obstacle_x != 12'd0) || (bus.obstacle_y != 12'd0);

    assign w_coll_now = bus.working && w_pixel_valid
                     && (bus.obstacle_x >= r_mx) && ({1'b0, bus.obstacle_x} <= w_x_hi)
                     && (bus.obstacle_y >= r_my) && ({1'b0, bus.obstacle_y} <= w_y_hi);

    // A pixel landing on the frame_start cycle belongs to the frame that is ending.
    assign w_eval = r_coll_flag | w_coll_now;

    always_comb begin
        w_state_nxt     = r_state;
        w_hit_nxt       = 1'b0;
        w_lives_nxt     = r_lives;
        w_inv_cnt_nxt   = r_inv_cnt;
        w_coll_flag_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_lives_nxt   = c_LIVES;
                w_inv_cnt_nxt = 8'd0;
                if (bus.game_on) begin
                    w_state_nxt = S_ARMED;
                end
            end

            S_ARMED: begin
                if (w_frame_start) begin
                    if (w_eval) begin
                        w_hit_nxt = 1'b1;
                        if (r_lives <= 3'd1) begin
                            w_lives_nxt = 3'd0;
                            w_state_nxt = S_OVER;
                        end else begin
                            w_lives_nxt   = r_lives - 3'd1;
                            w_inv_cnt_nxt = c_INV;
                            w_state_nxt   = S_INVULN;
                        end
                    end
                end else begin
                    w_coll_flag_nxt = w_eval;
                end
            end

            S_INVULN: begin
                if (w_frame_start) begin
                    if (r_inv_cnt <= 8'd1) begin
                        w_inv_cnt_nxt = 8'd0;
                        w_state_nxt   = S_ARMED;
                    end else begin
                        w_inv_cnt_nxt = r_inv_cnt - 8'd1;
                    end
                end
            end

            S_OVER: begin
                w_lives_nxt = 3'd0;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Leaving gameplay overrides everything, including a resolving frame.
        if (!bus.game_on) begin
            w_state_nxt     = S_IDLE;
            w_hit_nxt       = 1'b0;
            w_lives_nxt     = c_LIVES;
            w_inv_cnt_nxt   = 8'd0;
            w_coll_flag_nxt = 1'b0;
        end
    end

    assign w_invuln_nxt = (w_state_nxt == S_INVULN);
    assign w_over_nxt   = (w_state_nxt == S_OVER);

    always_ff @(posedge pclk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_hit       <= 1'b0;
            r_lives     <= c_LIVES;
            r_invuln    <= 1'b0;
            r_over      <= 1'b0;
            r_inv_cnt   <= 8'd0;
            r_coll_flag <= 1'b0;
            r_mx        <= 12'd0;
            r_my        <= 12'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_hit       <= w_hit_nxt;
            r_lives     <= w_lives_nxt;
            r_invuln    <= w_invuln_nxt;
            r_over      <= w_over_nxt;
            r_inv_cnt   <= w_inv_cnt_nxt;
            r_coll_flag <= w_coll_flag_nxt;
            if (w_frame_start) begin
                r_mx <= bus.mouse_xpos;
                r_my <= bus.mouse_ypos;
            end
        end
    end

    assign bus.hit          = r_hit;
    assign bus.lives        = r_lives;
    assign bus.invulnerable = r_invuln;
    assign bus.game_over    = r_over;

endmodule

`default_nettype wire

// File: tb/tb_collision_checker.sv
// ============================================================================
// Module      : tb_collision_checker
// Description : Directed and randomized scoreboard bench for collision_checker
//               against a frame-level game model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_collision_checker;

    localparam int PS   = 12;
    localparam int NL   = 3;
    localparam int NINV = 2;
    localparam int HW   = 16;
    localparam int VH   = 6;
    localparam int FLEN = HW * VH;

    logic pclk = 1'b0;
    logic rst  = 1'b0;
    always #5 pclk = ~pclk;

    collision_checker_if bus();

    collision_checker #(
        .POINTER_SIZE  (PS),
        .LIVES         (NL),
        .INVULN_FRAMES (NINV)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    typedef struct packed {
        logic       hit;
        logic [2:0] lives;
        logic       inv;
        logic       over;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Game model: frame-level bookkeeping of lives and remaining shield frames.
    int m_mx = 0, m_my = 0, m_lives = NL, m_inv_left = 0;
    bit m_frame_hit = 0, m_playing = 0, m_over = 0;
    int hc = 5, vc = 2;
    int mouse_x = 0, mouse_y = 0;

    task automatic model_and_push();
        int   ox, oy;
        bit   fs, inbox, any;
        exp_t e;
        ox    = int'(bus.obstacle_x);
        oy    = int'(bus.obstacle_y);
        fs    = (hc == 0) && (vc == 0);
        inbox = bus.working && (ox != 0 || oy != 0)
             && ox >= m_mx && ox < m_mx + PS && oy >= m_my && oy < m_my + PS;
        e     = '0;
        if (!rst) begin
            m_playing = 0; m_over = 0; m_lives = NL; m_inv_left = 0;
            m_frame_hit = 0; m_mx = 0; m_my = 0;
        end else begin
            if (!bus.game_on) begin
                m_playing = 0; m_over = 0; m_lives = NL; m_inv_left = 0; m_frame_hit = 0;
            end else if (!m_playing) begin
                m_playing = 1; m_frame_hit = 0;
            end else if (m_over) begin
                m_frame_hit = 0;
            end else if (m_inv_left > 0) begin
                m_frame_hit = 0;
                if (fs) m_inv_left--;
            end else begin
                any = m_frame_hit || inbox;
                if (fs) begin
                    m_frame_hit = 0;
                    if (any) begin
                        e.hit = 1'b1;
                        m_lives--;
                        if (m_lives == 0) m_over = 1;
                        else              m_inv_left = NINV;
                    end
                end else begin
                    m_frame_hit = any;
                end
            end
            if (fs) begin
                m_mx = int'(bus.mouse_xpos);
                m_my = int'(bus.mouse_ypos);
            end
        end
        e.lives = 3'(m_lives);
        e.inv   = m_playing && !m_over && (m_inv_left > 0);
        e.over  = m_over;
        sb.push_back(e);
    endtask

    task automatic tick(input int ox, input int oy, input bit wk);
        bus.hcount_in  = 12'(hc);
        bus.vcount_in  = 12'(vc);
        bus.obstacle_x = 12'(ox);
        bus.obstacle_y = 12'(oy);
        bus.working    = wk;
        bus.mouse_xpos = 12'(mouse_x);
        bus.mouse_ypos = 12'(mouse_y);
        model_and_push();
        @(posedge pclk);
        #1;
        hc++;
        if (hc == HW) begin
            hc = 0;
            vc = (vc + 1) % VH;
        end
    endtask

    task automatic to_frame_start();
        while (!(hc == 0 && vc == 0)) tick(0, 0, 0);
    endtask

    // One full frame starting at frame_start, with an optional single pixel at cycle 'at'.
    task automatic frame(input int px, input int py, input int at);
        for (int i = 0; i < FLEN; i++) begin
            if (i == at) tick(px, py, 1'b1);
            else         tick(0, 0, 1'b0);
        end
    endtask

    always @(negedge pclk) begin : monitor
        exp_t e;
        exp_t act;
        if (sb.size() != 0) begin
            e   = sb.pop_front();
            act = {bus.hit, bus.lives, bus.invulnerable, bus.game_over};
            n_cmp++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL outputs t=%0t got hit=%0b lives=%0d inv=%0b over=%0b expected hit=%0b lives=%0d inv=%0b over=%0b",
                         $time, act.hit, act.lives, act.inv, act.over, e.hit, e.lives, e.inv, e.over);
            end
        end
    end

    initial begin
        bus.game_on = 1'b0;
        rst = 1'b0;
        tick(0, 0, 0);
        tick(0, 0, 0);
        rst = 1'b1;
        tick(0, 0, 0);

        // Basic hit, ignored hits while shielded, box edge, second and third hits.
        mouse_x = 100; mouse_y = 100;
        bus.game_on = 1'b1;
        tick(0, 0, 0);
        to_frame_start();
        frame(0, 0, -1);
        frame(105, 110, 40);
        frame(105, 110, 10);
        frame(105, 110, 10);
        frame(112, 100, 20);
        frame(111, 111, 20);
        frame(100, 100, 5);
        frame(100, 100, 5);
        frame(105, 105, 50);
        frame(105, 105, 50);
        frame(105, 105, 50);
        bus.game_on = 1'b0;
        tick(0, 0, 0);
        tick(0, 0, 0);

        // No wrap near the right/bottom edge, and the (0,0) no-pixel marker.
        mouse_x = 4090; mouse_y = 4090;
        bus.game_on = 1'b1;
        to_frame_start();
        frame(5, 5, 30);
        frame(5, 5, 30);
        mouse_x = 0; mouse_y = 0;
        frame(0, 0, -1);
        frame(0, 0, 30);
        frame(0, 0, 31);

        // Reset in the middle of the shield window.
        frame(3, 3, 30);
        frame(0, 0, -1);
        for (int i = 0; i < 20; i++) tick(0, 0, 0);
        rst = 1'b0;
        tick(0, 0, 0);
        rst = 1'b1;
        to_frame_start();

        // game_on dropped on the resolving frame_start.
        frame(4, 4, 30);
        frame(4, 4, 30);
        bus.game_on = 1'b0;
        tick(0, 0, 0);
        bus.game_on = 1'b1;
        to_frame_start();

        // Randomized play.
        for (int f = 0; f < 80; f++) begin
            if ($urandom_range(0, 9) == 0) begin
                bus.game_on = 1'b0;
                repeat ($urandom_range(1, 4)) tick(0, 0, 0);
                bus.game_on = 1'b1;
            end
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b0;
                tick(0, 0, 0);
                rst = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) begin
                mouse_x = 4080 + int'($urandom_range(0, 15));
                mouse_y = 4080 + int'($urandom_range(0, 15));
            end else begin
                mouse_x = int'($urandom_range(0, 200));
                mouse_y = int'($urandom_range(0, 200));
            end
            for (int i = 0; i < FLEN; i++) begin
                if ($urandom_range(0, 47) == 0) begin
                    tick(mouse_x + int'($urandom_range(0, 17)) - 3,
                         mouse_y + int'($urandom_range(0, 17)) - 3,
                         $urandom_range(0, 5) != 0);
                end else begin
                    tick(0, 0, 0);
                end
                if ($urandom_range(0, 199) == 0) begin
                    mouse_x = int'($urandom_range(0, 200));
                end
            end
        end

        tick(0, 0, 0);
        @(negedge pclk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
